// File: rtl/comp_serial_if.sv
// comp_serial_if -- handshake and result bundle for the bit-serial comparator.
//   start, bit_valid, A, B : driven by the producer (master) toward comp_serial
//   busy, done, lt, gt, eq : registered status and verdict from comp_serial
// The master modport belongs to the producer/consumer, and the slave modport belongs to comp_serial.
interface comp_serial_if;
  logic start;
  logic bit_valid;
  logic A;
  logic B;
  logic busy;
  logic done;
  logic lt;
  logic gt;
  logic eq;

  modport master (
    output start, bit_valid, A, B,
    input  busy, done, lt, gt, eq
  );

  modport slave (
    input  start, bit_valid, A, B,
    output busy, done, lt, gt, eq
  );
endinterface

// File: rtl/comp_serial.sv
// comp_serial -- bit-serial magnitude comparator of two WIDTH-bit operands.
// Each cycle with bit_valid high while busy consumes one bit of A and one bit of B.
// After WIDTH bits it strobes done for one cycle with exactly one of lt/gt/eq set.
// The verdict holds until the next accepted start.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   cmp    : comp_serial_if.slave
//            (start, bit_valid, A, B in; busy, done, lt, gt, eq out)
//
// Configuration macro: COMP_SERIAL_LSB_FIRST_EN
//   undefined : bits arrive MSB first, and the first differing bit locks the verdict
//   defined   : bits arrive LSB first, and the last differing bit wins
module comp_serial #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  comp_serial_if.slave  cmp
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          decided_q, decided_d;   // a differing bit has been seen
  logic          sign_q, sign_d;         // 1: A was the larger at the deciding bit
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          lt_q, lt_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;

  logic          take_start_s;
  logic          take_bit_s;
  logic          last_bit_s;
  logic          diff_s;

  // Start is accepted only outside COMPARE; that cycle never samples A/B.
  assign take_start_s = (state_q != S_COMPARE) && cmp.start;
  assign take_bit_s   = (state_q == S_COMPARE) && cmp.bit_valid;
  assign last_bit_s   = take_bit_s && (cnt_q == LAST);
  assign diff_s       = cmp.A ^ cmp.B;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmp.start) state_d = S_COMPARE;
        else           state_d = S_IDLE;
      end
      S_COMPARE: begin
        if (last_bit_s) state_d = S_DONE;
        else            state_d = S_COMPARE;
      end
      S_DONE: begin
        if (cmp.start) state_d = S_COMPARE;
        else           state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  // busy/done are derived from the next state so they stay registered outputs.
  always_comb begin
    cnt_d     = cnt_q;
    decided_d = decided_q;
    sign_d    = sign_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    busy_d    = (state_d == S_COMPARE);
    done_d    = (state_d == S_DONE);

    if (take_start_s) begin
      cnt_d     = '0;
      decided_d = 1'b0;
      sign_d    = 1'b0;
      lt_d      = 1'b0;
      gt_d      = 1'b0;
      eq_d      = 1'b0;
    end else if (take_bit_s) begin
`ifdef COMP_SERIAL_LSB_FIRST_EN
      // LSB first: a later difference is more significant, so it overwrites.
      if (diff_s) begin
        decided_d = 1'b1;
        sign_d    = cmp.A;
      end else begin
        decided_d = decided_q;
      end
`else
      // MSB first: the first difference decides, and later bits are only counted.
      if (diff_s && !decided_q) begin
        decided_d = 1'b1;
        sign_d    = cmp.A;
      end else begin
        decided_d = decided_q;
      end
`endif
      if (last_bit_s) begin
        // Counter is left at WIDTH-1; it is cleared by the next start.
        lt_d = decided_d && !sign_d;
        gt_d = decided_d && sign_d;
        eq_d = !decided_d;
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      decided_q <= 1'b0;
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      sign_q    <= sign_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
    end
  end

  assign cmp.busy = busy_q;
  assign cmp.done = done_q;
  assign cmp.lt   = lt_q;
  assign cmp.gt   = gt_q;
  assign cmp.eq   = eq_q;

endmodule

// File: tb/tb_comp_serial.sv
// tb_comp_serial -- directed self-checking bench for comp_serial (WIDTH=8).
// Operands are serialised in the order the build expects, so every expected
// verdict is the plain magnitude comparison of the two 8-bit values.
module tb_comp_serial;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  comp_serial_if cif ();

  comp_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (cif.slave)
  );

  always #5 clk = ~clk;

  // Bit k (0-based, in transmission order) of operand v.
  function automatic logic bit_at(input logic [W-1:0] v, input int k);
`ifdef COMP_SERIAL_LSB_FIRST_EN
    bit_at = v[k];
`else
    bit_at = v[W-1-k];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    cif.start     = 1'b1;
    cif.bit_valid = 1'b0;
    tick();
    cif.start     = 1'b0;
  endtask

  // Sends nbits bits. If gap is set, an idle cycle is inserted before every bit except the first.
  // clean reports that busy=1 and done=0 held on every bit cycle.
  task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int nbits, input bit gap, output bit clean);
    clean = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      if (gap && k > 0) begin
        cif.bit_valid = 1'b0;
        tick();
      end
      cif.bit_valid = 1'b1;
      cif.A = bit_at(a, k);
      cif.B = bit_at(b, k);
      if (cif.busy !== 1'b1 || cif.done !== 1'b0) clean = 1'b0;
      tick();
    end
    cif.bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    cif.start = 1'b0; cif.bit_valid = 1'b0; cif.A = 1'b0; cif.B = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    n_total++;
    if ({cif.busy, cif.done, cif.lt, cif.gt, cif.eq} !== 5'b00000)
      $display("FAIL reset_outputs busy/done/lt/gt/eq=%b exp=00000",
               {cif.busy, cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_eq_a5();
    bit clean;
    do_start();
    n_total++;
    if (cif.busy !== 1'b1) $display("FAIL eq_busy_rise busy=%b exp=1", cif.busy);
    else n_pass++;
    send_bits(8'hA5, 8'hA5, W, 1'b0, clean);
    n_total++;
    if (clean !== 1'b1) $display("FAIL eq_busy_during busy/done wrong during bits, clean=%b exp=1", clean);
    else n_pass++;
    n_total++;
    if ({cif.busy, cif.done, cif.lt, cif.gt, cif.eq} !== 5'b01001)
      $display("FAIL eq_done busy/done/lt/gt/eq=%b exp=01001",
               {cif.busy, cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
    tick();
    n_total++;
    if ({cif.busy, cif.done, cif.lt, cif.gt, cif.eq} !== 5'b00001)
      $display("FAIL eq_hold_idle busy/done/lt/gt/eq=%b exp=00001",
               {cif.busy, cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
  endtask

  task automatic test_gt_early();
    bit clean;
    do_start();
    n_total++;
    if ({cif.lt, cif.gt, cif.eq} !== 3'b000)
      $display("FAIL gt_clear_on_start lt/gt/eq=%b exp=000", {cif.lt, cif.gt, cif.eq});
    else n_pass++;
    send_bits(8'h80, 8'h7F, W, 1'b0, clean);
    n_total++;
    if (clean !== 1'b1) $display("FAIL gt_no_early_done clean=%b exp=1", clean);
    else n_pass++;
    n_total++;
    if ({cif.done, cif.lt, cif.gt, cif.eq} !== 4'b1010)
      $display("FAIL gt_verdict done/lt/gt/eq=%b exp=1010", {cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
    tick();
  endtask

  task automatic test_gaps();
    bit clean;
    do_start();
    // 1 start cycle + 8 bits + 7 gap cycles: done is visible 16 cycles after start.
    send_bits(8'h01, 8'h02, W, 1'b1, clean);
    n_total++;
    if (clean !== 1'b1) $display("FAIL gaps_no_early_done clean=%b exp=1", clean);
    else n_pass++;
    n_total++;
    if ({cif.done, cif.lt, cif.gt, cif.eq} !== 4'b1100)
      $display("FAIL gaps_verdict done/lt/gt/eq=%b exp=1100", {cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
    tick();
    n_total++;
    if (cif.done !== 1'b0) $display("FAIL gaps_done_one_cycle done=%b exp=0", cif.done);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit clean;
    do_start();
    send_bits(8'hF0, 8'h00, 4, 1'b0, clean);
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({cif.busy, cif.done, cif.lt, cif.gt, cif.eq} !== 5'b00000)
      $display("FAIL async_reset busy/done/lt/gt/eq=%b exp=00000",
               {cif.busy, cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    send_bits(8'h10, 8'h10, W, 1'b0, clean);
    n_total++;
    if ({clean, cif.done, cif.lt, cif.gt, cif.eq} !== 5'b11001)
      $display("FAIL after_reset_eq clean/done/lt/gt/eq=%b exp=11001",
               {clean, cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    bit clean;
    do_start();
    send_bits(8'h3C, 8'h3D, 3, 1'b0, clean);
    // A stray start mid-comparison must not restart the comparison.
    cif.start = 1'b1;
    tick();
    cif.start = 1'b0;
    for (int k = 3; k < W; k++) begin
      cif.bit_valid = 1'b1;
      cif.A = bit_at(8'h3C, k);
      cif.B = bit_at(8'h3D, k);
      tick();
    end
    cif.bit_valid = 1'b0;
    n_total++;
    if ({cif.done, cif.lt, cif.gt, cif.eq} !== 4'b1100)
      $display("FAIL b2b_first_verdict done/lt/gt/eq=%b exp=1100", {cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
    // Start in the done cycle, with bit_valid high and differing bits that must not be sampled.
    cif.start = 1'b1; cif.bit_valid = 1'b1; cif.A = 1'b1; cif.B = 1'b0;
    tick();
    cif.start = 1'b0; cif.bit_valid = 1'b0;
    n_total++;
    if ({cif.busy, cif.done, cif.lt, cif.gt, cif.eq} !== 5'b10000)
      $display("FAIL b2b_restart busy/done/lt/gt/eq=%b exp=10000",
               {cif.busy, cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
    send_bits(8'h00, 8'h00, W, 1'b0, clean);
    n_total++;
    if ({clean, cif.done, cif.lt, cif.gt, cif.eq} !== 5'b11001)
      $display("FAIL b2b_second_verdict clean/done/lt/gt/eq=%b exp=11001",
               {clean, cif.done, cif.lt, cif.gt, cif.eq});
    else n_pass++;
    tick();
    n_total++;
    if ({cif.busy, cif.done} !== 2'b00)
      $display("FAIL b2b_back_idle busy/done=%b exp=00", {cif.busy, cif.done});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_eq_a5();
    test_gt_early();
    test_gaps();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
